spi_ram_node: RTL and testbench
===============================

# spi_ram_node

Parametrised SPI-slave memory node: a serial front end, command decoder and single-port RAM merged into one block with configurable data and address widths, optional address auto-increment and streaming of back-to-back frames under one SS_n assertion. It sits at the chip boundary, replacing the fixed 8-bit slave-plus-RAM pairing. It is the only consumer of MOSI/SS_n and the only driver of MISO. Serial bits are sampled on the system clock.

## Interface
- DATA_WIDTH, 8: word width W; also width of the frame payload field.
- ADDR_WIDTH, 8: address width; must be ≤ DATA_WIDTH; memory depth = 2**ADDR_WIDTH.
- AUTO_INC, 1: 1 = pointer increments after each data write/read; 0 = pointer fixed.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- SS_n  in  1  slave select, active-low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse after a completed (non-aborted) frame executes.

## Operation
- Frame is W+2 bits, MSB first: cmd[1:0], then payload[W-1:0].
- Commands:
  - 00: wr_ptr ← payload[ADDR_WIDTH-1:0].
  - 01: mem[wr_ptr] ← payload; then wr_ptr+1 if AUTO_INC.
  - 10: rd_ptr ← payload[ADDR_WIDTH-1:0].
  - 11: payload is a dummy; return mem[rd_ptr] on MISO; then rd_ptr+1 if AUTO_INC.
- Payload bits above ADDR_WIDTH are ignored for address commands.
- Pointers wrap from 2**ADDR_WIDTH-1 to 0. Pointers are independent. Command 11 with no prior 10 uses the current rd_ptr (0 after reset).
- States:
  - IDLE: on an edge with SS_n=0, capture bit 0 and go to RX.
  - RX: capture bits 1..W+1; after the last bit, go to EXEC.
  - EXEC: perform the command and pulse frame_done. Cmd 11 issues a registered RAM read and goes to LOAD; other commands go to IDLE.
  - LOAD: load the shift register; MISO ← bit W-1; go to TX.
  - TX: shift W-1 times; on the next edge go to IDLE with MISO ← 0.
- Any edge with SS_n=1 in any state is an abort:
  - state ← IDLE; bit counter cleared; MISO ← 0.
  - No memory write, no pointer change, no frame_done.
- This includes SS_n=1 on the EXEC edge.
- Streaming: while SS_n stays low, IDLE immediately starts the next frame. No SS_n toggle is required between frames.
- Memory contents are not reset.
- Reset values: MISO=0, busy=0, frame_done=0, wr_ptr=0, rd_ptr=0, state=IDLE.
- Reset mid-frame has the same effect as abort and additionally clears the pointers.

## Timing
- Edge 0 is the first rising edge with SS_n=0 in IDLE. MOSI bit i is sampled on edge i, for i = 0..W+1.
- Edge W+2 is EXEC. MOSI is ignored; the memory write or pointer update is visible from this edge; frame_done is high for the following cycle.
- Write/address frame period is W+3 cycles (11 for W=8). The next frame's bit 0 is sampled on edge W+3.
- Read-data frame:
  - Edge W+2: RAM read.
  - Edge W+3: MISO = data[W-1].
  - MISO holds data[W-1-k] during the cycle after edge W+3+k, for k = 0..W-1.
  - Edge 2W+3: MISO returns to 0, IDLE.
  - Next frame bit 0 on edge 2W+4, a period of 2W+4 cycles (20 for W=8).
- A read-data frame immediately after a data write to the same address returns the new data. No hazard cycle is needed.
- MOSI during LOAD/TX is ignored.

## Test plan
- Default params:
  - Frames 00/0x10, 01/0xA5, 01/0x3C, 10/0x10, 11/xx, 11/xx streamed under one SS_n low.
  - Required: MISO 0xA5 then 0x3C; six frame_done pulses at the specified edges; wr_ptr ends 0x12, rd_ptr ends 0x12.
- Wrap:
  - 00/0xFF, 01/0x11, 01/0x22, then read back from 0xFF and 0x00.
  - Required: 0x11 and 0x22; wr_ptr = 0x01.
- Abort:
  - SS_n high after cmd 01 plus 5 payload bits, then a full read of that address.
  - Required: old contents returned; no frame_done on the abort; wr_ptr unchanged.
  - Repeat with SS_n high exactly on the EXEC edge.
- AUTO_INC=0:
  - 00/0x05, 01/0x77, 01/0x88, read 0x05.
  - Required: 0x88; wr_ptr stays 0x05.
- Reset mid-TX:
  - rst_n=0 on edge W+6 of a read-data frame.
  - Required: MISO=0, busy=0 on the next cycle; pointers 0; the next frame decodes normally.
- DATA_WIDTH=16, ADDR_WIDTH=10:
  - Write 0xBEEF at 0x3FF, then 0x1234 (wraps to 0x000); read both.
  - Required: exact 16-bit words; 19-cycle write and 36-cycle read frame periods.

Source files
------------

// File: rtl/spi_ram_node.sv
// SPI-slave memory node: serial frame receiver, command decoder and single-port RAM.
// Frames are cmd[1:0] followed by a DATA_WIDTH payload, MSB first, sampled on clk.
module spi_ram_node #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_done
);
    localparam int W     = DATA_WIDTH;
    localparam int FW    = W + 2;
    localparam int CW    = $clog2(FW) + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, RX, EXEC, LOAD, TX} state_t;

    state_t                state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [FW-1:0]         frame_q;
    logic [W-1:0]          shift_q;
    logic [W-1:0]          rdata_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic                  miso_q;
    logic                  done_q;

    logic [W-1:0] mem [DEPTH];

    logic [1:0]   cmd;
    logic [W-1:0] payload;
    logic         exec_ok;
    logic         mem_we;
    logic         mem_re;

    assign cmd     = frame_q[FW-1:W];
    assign payload = frame_q[W-1:0];
    // An EXEC edge only takes effect if select is still asserted and not in reset.
    assign exec_ok = (state_q == EXEC) && !SS_n && rst_n;
    assign mem_we  = exec_ok && (cmd == 2'b01);
    assign mem_re  = exec_ok && (cmd == 2'b11);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= payload;
        end
        if (mem_re) begin
            rdata_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            miso_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (SS_n) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        frame_q   <= {frame_q[FW-2:0], MOSI};
                        bit_cnt_q <= CW'(1);
                        state_q   <= RX;
                    end
                    RX: begin
                        frame_q <= {frame_q[FW-2:0], MOSI};
                        if (bit_cnt_q == CW'(FW - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= EXEC;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                    EXEC: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        case (cmd)
                            2'b00: wr_ptr_q <= payload[ADDR_WIDTH-1:0];
                            2'b01: if (AUTO_INC != 0) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
                            2'b10: rd_ptr_q <= payload[ADDR_WIDTH-1:0];
                            default: begin
                                if (AUTO_INC != 0) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
                                state_q <= LOAD;
                            end
                        endcase
                    end
                    LOAD: begin
                        shift_q   <= rdata_q;
                        miso_q    <= rdata_q[W-1];
                        bit_cnt_q <= '0;
                        state_q   <= TX;
                    end
                    TX: begin
                        // W-1 shifts after LOAD, then one more edge to return MISO low.
                        if (bit_cnt_q == CW'(W - 1)) begin
                            miso_q    <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            shift_q   <= {shift_q[W-2:0], 1'b0};
                            miso_q    <= shift_q[W-2];
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign MISO       = miso_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_spi_ram_node.sv
// Self-checking bench for spi_ram_node: three parameterisations driven from one
// frame engine, directed vector table plus randomized frames against a memory model.
module tb_spi_ram_node;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n_v;
    logic [2:0] ss_n_v;
    logic [2:0] mosi_v;
    wire  [2:0] miso_v;
    wire  [2:0] busy_v;
    wire  [2:0] done_v;

    spi_ram_node dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .SS_n(ss_n_v[0]), .MOSI(mosi_v[0]),
        .MISO(miso_v[0]), .busy(busy_v[0]), .frame_done(done_v[0])
    );
    spi_ram_node #(.AUTO_INC(0)) dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .SS_n(ss_n_v[1]), .MOSI(mosi_v[1]),
        .MISO(miso_v[1]), .busy(busy_v[1]), .frame_done(done_v[1])
    );
    spi_ram_node #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut2 (
        .clk(clk), .rst_n(rst_n_v[2]), .SS_n(ss_n_v[2]), .MOSI(mosi_v[2]),
        .MISO(miso_v[2]), .busy(busy_v[2]), .frame_done(done_v[2])
    );

    int iw[3]  = '{8, 8, 16};
    int ia[3]  = '{8, 8, 10};
    int iai[3] = '{1, 0, 1};

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain memory array and pointers per instance.
    logic [15:0] m_mem[3][1024];
    bit          m_known[3][1024];
    int          m_wp[3];
    int          m_rp[3];

    typedef struct {
        int          s;
        logic [1:0]  cmd;
        logic [15:0] pl;
        bit          is_rd;
        logic [15:0] exp_rd;
        bit          chk_ptr;
        int          exp_wp;
        int          exp_rp;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    endtask

    function automatic int dut_wp(input int s);
        case (s)
            0: return int'(dut0.wr_ptr_q);
            1: return int'(dut1.wr_ptr_q);
            default: return int'(dut2.wr_ptr_q);
        endcase
    endfunction

    function automatic int dut_rp(input int s);
        case (s)
            0: return int'(dut0.rd_ptr_q);
            1: return int'(dut1.rd_ptr_q);
            default: return int'(dut2.rd_ptr_q);
        endcase
    endfunction

    function automatic logic frame_bit(input int w, input logic [1:0] cmd, input logic [15:0] pl, input int i);
        if (i < 2) return cmd[1-i];
        return pl[w+1-i];
    endfunction

    task automatic model_step(input int s, input logic [1:0] cmd, input logic [15:0] pl,
                              output logic [15:0] rd, output bit known);
        int amask;
        int wmask;
        amask = (1 << ia[s]) - 1;
        wmask = (1 << iw[s]) - 1;
        rd    = '0;
        known = 1'b0;
        case (cmd)
            2'd0: m_wp[s] = int'(pl) & amask;
            2'd1: begin
                m_mem[s][m_wp[s]]   = 16'(int'(pl) & wmask);
                m_known[s][m_wp[s]] = 1'b1;
                if (iai[s] != 0) m_wp[s] = (m_wp[s] + 1) & amask;
            end
            2'd2: m_rp[s] = int'(pl) & amask;
            default: begin
                rd    = m_mem[s][m_rp[s]];
                known = m_known[s][m_rp[s]];
                if (iai[s] != 0) m_rp[s] = (m_rp[s] + 1) & amask;
            end
        endcase
    endtask

    // Drives one full frame with SS_n low from the current negedge; checks the
    // frame_done edge, busy profile, idle-low MISO and (optionally) read data.
    task automatic run_frame(input int s, input logic [1:0] cmd, input logic [15:0] pl,
                             input bit chk_rd, input logic [15:0] exp_rd, input string nm);
        int w;
        int len;
        int done_cnt;
        int done_edge;
        int busy_err;
        int miso_err;
        logic [15:0] rd;
        w         = iw[s];
        len       = (cmd == 2'd3) ? 2 * w + 4 : w + 3;
        done_cnt  = 0;
        done_edge = -1;
        busy_err  = 0;
        miso_err  = 0;
        rd        = '0;
        for (int j = 0; j < 3; j++) if (j != s) ss_n_v[j] = 1'b1;
        for (int e = 0; e < len; e++) begin
            ss_n_v[s] = 1'b0;
            mosi_v[s] = (e < w + 2) ? frame_bit(w, cmd, pl, e) : 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (done_v[s]) begin
                done_cnt++;
                done_edge = e;
            end
            if (busy_v[s] !== (e != len - 1)) busy_err++;
            if (cmd == 2'd3 && e >= w + 3 && e <= 2 * w + 2) rd[w-1-(e-w-3)] = miso_v[s];
            else if (miso_v[s] !== 1'b0) miso_err++;
        end
        check({nm, " frame_done edge"}, (done_cnt == 1) ? done_edge : -1, w + 2);
        check({nm, " busy profile errors"}, busy_err, 0);
        check({nm, " idle MISO errors"}, miso_err, 0);
        if (chk_rd) check({nm, " read data"}, rd, exp_rd);
    endtask

    task automatic do_frame(input int s, input logic [1:0] cmd, input logic [15:0] pl, input string nm);
        logic [15:0] rd;
        bit known;
        model_step(s, cmd, pl, rd, known);
        run_frame(s, cmd, pl, known && (cmd == 2'd3), rd, nm);
    endtask

    // Sends nbits frame bits, then raises SS_n on the following edge.
    task automatic abort_frame(input int s, input logic [1:0] cmd, input logic [15:0] pl,
                               input int nbits, input string nm);
        int done_cnt;
        done_cnt = 0;
        for (int j = 0; j < 3; j++) if (j != s) ss_n_v[j] = 1'b1;
        for (int e = 0; e < nbits; e++) begin
            ss_n_v[s] = 1'b0;
            mosi_v[s] = frame_bit(iw[s], cmd, pl, e);
            @(posedge clk);
            @(negedge clk);
            if (done_v[s]) done_cnt++;
        end
        ss_n_v[s] = 1'b1;
        mosi_v[s] = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        if (done_v[s]) done_cnt++;
        check({nm, " frame_done count"}, done_cnt, 0);
        check({nm, " busy after abort"}, busy_v[s], 1'b0);
        check({nm, " MISO after abort"}, miso_v[s], 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        bit known;
        int w;

        tbl[0]  = '{0, 2'd0, 16'h0010, 0, 16'h0000, 0, 0, 0};
        tbl[1]  = '{0, 2'd1, 16'h00A5, 0, 16'h0000, 0, 0, 0};
        tbl[2]  = '{0, 2'd1, 16'h003C, 0, 16'h0000, 0, 0, 0};
        tbl[3]  = '{0, 2'd2, 16'h0010, 0, 16'h0000, 0, 0, 0};
        tbl[4]  = '{0, 2'd3, 16'h005E, 1, 16'h00A5, 0, 0, 0};
        tbl[5]  = '{0, 2'd3, 16'h00C1, 1, 16'h003C, 1, 'h12, 'h12};
        tbl[6]  = '{0, 2'd0, 16'h00FF, 0, 16'h0000, 0, 0, 0};
        tbl[7]  = '{0, 2'd1, 16'h0011, 0, 16'h0000, 0, 0, 0};
        tbl[8]  = '{0, 2'd1, 16'h0022, 0, 16'h0000, 0, 0, 0};
        tbl[9]  = '{0, 2'd2, 16'h00FF, 0, 16'h0000, 0, 0, 0};
        tbl[10] = '{0, 2'd3, 16'h0000, 1, 16'h0011, 0, 0, 0};
        tbl[11] = '{0, 2'd3, 16'h00FF, 1, 16'h0022, 1, 'h01, 'h01};
        tbl[12] = '{1, 2'd0, 16'h0005, 0, 16'h0000, 0, 0, 0};
        tbl[13] = '{1, 2'd1, 16'h0077, 0, 16'h0000, 0, 0, 0};
        tbl[14] = '{1, 2'd1, 16'h0088, 0, 16'h0000, 0, 0, 0};
        tbl[15] = '{1, 2'd2, 16'h0005, 0, 16'h0000, 0, 0, 0};
        tbl[16] = '{1, 2'd3, 16'h0000, 1, 16'h0088, 1, 'h05, 'h05};
        tbl[17] = '{2, 2'd0, 16'h03FF, 0, 16'h0000, 0, 0, 0};
        tbl[18] = '{2, 2'd1, 16'hBEEF, 0, 16'h0000, 0, 0, 0};
        tbl[19] = '{2, 2'd1, 16'h1234, 0, 16'h0000, 0, 0, 0};
        tbl[20] = '{2, 2'd2, 16'hFFFF, 0, 16'h0000, 0, 0, 0};
        tbl[21] = '{2, 2'd3, 16'h0000, 1, 16'hBEEF, 0, 0, 0};
        tbl[22] = '{2, 2'd3, 16'h0000, 1, 16'h1234, 1, 'h001, 'h001};

        for (int s = 0; s < 3; s++) begin
            m_wp[s] = 0;
            m_rp[s] = 0;
            for (int a = 0; a < 1024; a++) m_known[s][a] = 1'b0;
        end

        rst_n_v = 3'b000;
        ss_n_v  = 3'b111;
        mosi_v  = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset inst%0d MISO", s), miso_v[s], 1'b0);
            check($sformatf("reset inst%0d busy", s), busy_v[s], 1'b0);
            check($sformatf("reset inst%0d frame_done", s), done_v[s], 1'b0);
            check($sformatf("reset inst%0d wr_ptr", s), dut_wp(s), 0);
            check($sformatf("reset inst%0d rd_ptr", s), dut_rp(s), 0);
        end
        rst_n_v = 3'b111;

        // Directed table: default stream, wrap, AUTO_INC=0, 16/10-bit widths.
        for (int i = 0; i < 23; i++) begin
            model_step(tbl[i].s, tbl[i].cmd, tbl[i].pl, rd, known);
            run_frame(tbl[i].s, tbl[i].cmd, tbl[i].pl, tbl[i].is_rd, tbl[i].exp_rd,
                      $sformatf("vec%0d", i));
            if (tbl[i].chk_ptr) begin
                check($sformatf("vec%0d wr_ptr", i), dut_wp(tbl[i].s), tbl[i].exp_wp);
                check($sformatf("vec%0d rd_ptr", i), dut_rp(tbl[i].s), tbl[i].exp_rp);
            end
        end

        // Abort mid-payload, then abort exactly on the EXEC edge.
        for (int k = 0; k < 2; k++) begin
            do_frame(0, 2'd0, 16'h0040, "abort setup ptr");
            do_frame(0, 2'd1, 16'h005A + 16'(k), "abort setup write");
            do_frame(0, 2'd0, 16'h0040, "abort ptr");
            abort_frame(0, 2'd1, 16'h00C3, (k == 0) ? 7 : 10, $sformatf("abort%0d", k));
            check($sformatf("abort%0d wr_ptr", k), dut_wp(0), 'h40);
            model_step(0, 2'd2, 16'h0040, rd, known);
            run_frame(0, 2'd2, 16'h0040, 1'b0, 16'h0000, "abort rd ptr");
            model_step(0, 2'd3, 16'h0000, rd, known);
            run_frame(0, 2'd3, 16'h0000, 1'b1, 16'h005A + 16'(k), $sformatf("abort%0d readback", k));
        end

        // Fill instance 0 so random reads always have known data.
        do_frame(0, 2'd0, 16'h0000, "fill ptr");
        for (int i = 0; i < 256; i++) do_frame(0, 2'd1, 16'($urandom), $sformatf("fill%0d", i));

        // Reset asserted on edge W+6 of a read-data frame.
        w = iw[0];
        model_step(0, 2'd3, 16'h0000, rd, known);
        for (int e = 0; e < w + 6; e++) begin
            ss_n_v[0] = 1'b0;
            mosi_v[0] = (e < w + 2) ? frame_bit(w, 2'd3, 16'h0000, e) : 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        rst_n_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset mid-TX MISO", miso_v[0], 1'b0);
        check("reset mid-TX busy", busy_v[0], 1'b0);
        check("reset mid-TX wr_ptr", dut_wp(0), 0);
        check("reset mid-TX rd_ptr", dut_rp(0), 0);
        rst_n_v[0] = 1'b1;
        ss_n_v[0]  = 1'b1;
        m_wp[0] = 0;
        m_rp[0] = 0;
        do_frame(0, 2'd3, 16'h0000, "post-reset read");
        do_frame(0, 2'd1, 16'h0066, "post-reset write");
        do_frame(0, 2'd2, 16'h0000, "post-reset rd ptr");
        do_frame(0, 2'd3, 16'h0000, "post-reset readback");

        // Randomized frames and aborts on every instance.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    abort_frame(s, 2'($urandom), 16'($urandom), $urandom_range(1, iw[s] + 2),
                                $sformatf("rnd inst%0d abort%0d", s, i));
                end else begin
                    do_frame(s, 2'($urandom), 16'($urandom), $sformatf("rnd inst%0d frame%0d", s, i));
                end
            end
            check($sformatf("rnd inst%0d wr_ptr", s), dut_wp(s), m_wp[s]);
            check($sformatf("rnd inst%0d rd_ptr", s), dut_rp(s), m_rp[s]);
        end

        ss_n_v = 3'b111;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
